// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Turns per-stage RAW match flags into PC hold, IF/ID hold,
//            ID/EX bubble and IF/ID flush. A down-counter sizes each stall
//            from the producer's distance to WB. Also handles taken-branch
//            squash and HALT freeze.
// Options  : STALL_PERF_CNT_EN - builds the saturating stall_cycles_o counter
//            (otherwise stall_cycles_o is tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int STALL_EX  = 3,
  parameter int STALL_MEM = 2,
  parameter int STALL_WB  = 1,
  parameter int CNT_W     = 2,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hz_id_ex_i,
  input  logic              hz_ex_mem_i,
  input  logic              hz_mem_wb_i,
  input  logic              branch_taken_i,
  input  logic              halt_req_i,
  output logic              pc_stall_o,
  output logic              if_id_stall_o,
  output logic              id_ex_bubble_o,
  output logic              if_id_flush_o,
  output logic              halted_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  localparam int LEN_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LEN_W-1:0] w_stall_len;
  logic             w_stall;   // hazard stall (excludes HALT freeze)
  logic             w_flush;
  logic             w_halted;

  // Stall length: the nearest producer dictates how long ID must wait.
  always_comb begin
    w_stall_len = '0;
    if (hz_id_ex_i)       w_stall_len = LEN_W'(STALL_EX);
    else if (hz_ex_mem_i) w_stall_len = LEN_W'(STALL_MEM);
    else if (hz_mem_wb_i) w_stall_len = LEN_W'(STALL_WB);
  end

  // State and remaining-stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and raw control decode; branch squash beats any hazard.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_halted = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (branch_taken_i) begin
          w_flush = 1'b1;
          cnt_d   = '0;
        end else if (w_stall_len != '0) begin
          // First stall cycle is this one, so the counter holds the rest.
          w_stall = 1'b1;
          if (w_stall_len > LEN_W'(1)) begin
            cnt_d   = CNT_W'(w_stall_len - LEN_W'(1));
            state_d = S_STALL;
          end
        end else if (halt_req_i) begin
          state_d = S_HALT;
        end
      end
      S_STALL: begin
        if (branch_taken_i) begin
          w_flush = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          w_stall = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, regardless of inputs.
  assign pc_stall_o     = rst_n & (w_stall | w_halted);
  assign if_id_stall_o  = rst_n & (w_stall | w_halted);
  assign id_ex_bubble_o = rst_n & (w_stall | w_halted | w_flush);
  assign if_id_flush_o  = rst_n & w_flush;
  assign halted_o       = rst_n & w_halted;

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  // Saturating count of hazard-stall cycles; HALT freeze is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (w_stall && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign stall_cycles_o = perf_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
`default_nettype wire
